// File: rtl/datapath_controller_pkg.sv
// Shared definitions for the general datapath controller: opcodes, A-source
// selects and the 4-bit state encodings (also imported by the datapath bench).
package datapath_controller_pkg;

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_INPUT = 3'b100;
   localparam logic [2:0] OP_JZ    = 3'b101;
   localparam logic [2:0] OP_JPOS  = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   localparam logic [1:0] ASEL_ALU = 2'b00;
   localparam logic [1:0] ASEL_IN  = 2'b01;
   localparam logic [1:0] ASEL_RAM = 2'b10;

   typedef enum logic [3:0] {
      S_START   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_LOAD    = 4'd3,
      S_STORE   = 4'd4,
      S_ADD     = 4'd5,
      S_SUB     = 4'd6,
      S_INPUT   = 4'd7,
      S_RELEASE = 4'd8,
      S_JZ      = 4'd9,
      S_JPOS    = 4'd10,
      S_HALT    = 4'd11
   } state_t;

endpackage

// File: rtl/datapath_controller.sv
// Fetch/decode/execute sequencer for the 8-bit general datapath. Moore outputs
// from the state register, plus Mealy terms on Enter, Aeq0 and Apos.
module datapath_controller
   import datapath_controller_pkg::*;
#(
   parameter bit INPUT_RELEASE = 1'b1
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [2:0] IR,
   input  logic       Aeq0,
   input  logic       Apos,
   input  logic       Enter,
   output logic       PCload,
   output logic       JMPmux,
   output logic       IRload,
   output logic       Meminst,
   output logic       MemWr,
   output logic [1:0] Asel,
   output logic       Aload,
   output logic       Sub,
   output logic       Halt,
   output logic [3:0] State
);

   state_t state;
   state_t next_state;

   always_ff @(posedge Clock) begin
      if (Reset) state <= S_START;
      else       state <= next_state;
   end

   assign State = state;

   always_comb begin
      next_state = state;
      PCload     = 1'b0;
      JMPmux     = 1'b0;
      IRload     = 1'b0;
      Meminst    = 1'b0;
      MemWr      = 1'b0;
      Asel       = ASEL_ALU;
      Aload      = 1'b0;
      Sub        = 1'b0;
      Halt       = 1'b0;

      case (state)
         S_START: next_state = S_FETCH;

         // IR <= RAM[PC] and PC <= PC+1 on the same edge
         S_FETCH: begin
            IRload     = 1'b1;
            Meminst    = 1'b1;
            PCload     = 1'b1;
            next_state = S_DECODE;
         end

         S_DECODE: begin
            case (IR)
               OP_LOAD:  next_state = S_LOAD;
               OP_STORE: next_state = S_STORE;
               OP_ADD:   next_state = S_ADD;
               OP_SUB:   next_state = S_SUB;
               OP_INPUT: next_state = S_INPUT;
               OP_JZ:    next_state = S_JZ;
               OP_JPOS:  next_state = S_JPOS;
               default:  next_state = S_HALT;
            endcase
         end

         S_LOAD: begin
            Asel       = ASEL_RAM;
            Aload      = 1'b1;
            next_state = S_FETCH;
         end

         S_STORE: begin
            MemWr      = 1'b1;
            next_state = S_FETCH;
         end

         S_ADD: begin
            Aload      = 1'b1;
            next_state = S_FETCH;
         end

         S_SUB: begin
            Sub        = 1'b1;
            Aload      = 1'b1;
            next_state = S_FETCH;
         end

         // RELEASE keeps a held key from being taken as a second entry
         S_INPUT: begin
            if (Enter) begin
               Asel       = ASEL_IN;
               Aload      = 1'b1;
               next_state = INPUT_RELEASE ? S_RELEASE : S_FETCH;
            end
         end

         S_RELEASE: begin
            if (!Enter) next_state = S_FETCH;
         end

         S_JZ: begin
            if (Aeq0) begin
               PCload = 1'b1;
               JMPmux = 1'b1;
            end
            next_state = S_FETCH;
         end

         S_JPOS: begin
            if (Apos) begin
               PCload = 1'b1;
               JMPmux = 1'b1;
            end
            next_state = S_FETCH;
         end

         S_HALT: Halt = 1'b1;

         default: next_state = S_START;
      endcase
   end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed, table-driven bench for datapath_controller: each row drives inputs,
// checks State and the control outputs before the next rising edge.
module tb_datapath_controller;
   import datapath_controller_pkg::*;

   logic       Clock;
   logic       Reset;
   logic [2:0] IR;
   logic       Aeq0;
   logic       Apos;
   logic       Enter;
   logic       PCload;
   logic       JMPmux;
   logic       IRload;
   logic       Meminst;
   logic       MemWr;
   logic [1:0] Asel;
   logic       Aload;
   logic       Sub;
   logic       Halt;
   logic [3:0] State;

   // Output vector order: {PCload, JMPmux, IRload, Meminst, MemWr, Asel, Aload, Sub, Halt}
   localparam logic [9:0] O_NONE  = 10'b0000000000;
   localparam logic [9:0] O_FETCH = 10'b1011000000;
   localparam logic [9:0] O_LOAD  = 10'b0000010100;
   localparam logic [9:0] O_STORE = 10'b0000100000;
   localparam logic [9:0] O_ADD   = 10'b0000000100;
   localparam logic [9:0] O_SUB   = 10'b0000000110;
   localparam logic [9:0] O_IN    = 10'b0000001100;
   localparam logic [9:0] O_JMP   = 10'b1100000000;
   localparam logic [9:0] O_HALT  = 10'b0000000001;

   typedef struct {
      logic       rst;
      logic [2:0] ir;
      logic       aeq0;
      logic       apos;
      logic       enter;
      logic [3:0] st;
      logic [9:0] outs;
   } vec_t;

   vec_t vecs[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   datapath_controller #(.INPUT_RELEASE(1'b1)) dut (
      .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos),
      .Enter(Enter), .PCload(PCload), .JMPmux(JMPmux), .IRload(IRload),
      .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload),
      .Sub(Sub), .Halt(Halt), .State(State)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic addRow(input logic rst, input logic [2:0] ir, input logic aeq0,
                         input logic apos, input logic enter,
                         input logic [3:0] st, input logic [9:0] outs);
      vec_t v;
      v.rst = rst; v.ir = ir; v.aeq0 = aeq0; v.apos = apos; v.enter = enter;
      v.st = st; v.outs = outs;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic rst, input logic [2:0] ir, input logic aeq0,
                                input logic apos, input logic enter);
      @(negedge Clock);
      Reset = rst; IR = ir; Aeq0 = aeq0; Apos = apos; Enter = enter;
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] st, input logic [9:0] outs);
      logic [9:0] got;
      got = {PCload, JMPmux, IRload, Meminst, MemWr, Asel, Aload, Sub, Halt};
      testsRun++;
      if (State !== st) begin
         testsFailed++;
         $display("[TB] FAIL %s state: got %0d expected %0d", name, State, st);
      end
      testsRun++;
      if (got !== outs) begin
         testsFailed++;
         $display("[TB] FAIL %s outputs: got %b expected %b", name, got, outs);
      end
   endtask

   initial begin
      Reset = 1'b1; IR = 3'b000; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;

      //      rst ir      aeq0  apos  enter  state  outputs
      addRow(1, 3'b000, 0, 0, 0, 4'd0,  O_NONE);
      addRow(1, 3'b000, 0, 0, 0, 4'd0,  O_NONE);
      addRow(0, 3'b000, 0, 0, 0, 4'd0,  O_NONE);
      addRow(0, 3'b000, 0, 0, 0, 4'd1,  O_FETCH);
      addRow(0, 3'b000, 0, 0, 0, 4'd2,  O_NONE);
      addRow(0, 3'b000, 0, 0, 0, 4'd3,  O_LOAD);
      addRow(0, 3'b011, 0, 0, 0, 4'd1,  O_FETCH);
      addRow(0, 3'b011, 0, 0, 0, 4'd2,  O_NONE);
      addRow(0, 3'b011, 0, 0, 0, 4'd6,  O_SUB);
      addRow(0, 3'b010, 0, 0, 0, 4'd1,  O_FETCH);
      addRow(0, 3'b010, 0, 0, 0, 4'd2,  O_NONE);
      addRow(0, 3'b010, 0, 0, 0, 4'd5,  O_ADD);
      addRow(0, 3'b001, 0, 0, 0, 4'd1,  O_FETCH);
      addRow(0, 3'b001, 0, 0, 0, 4'd2,  O_NONE);
      addRow(0, 3'b001, 0, 0, 0, 4'd4,  O_STORE);
      addRow(0, 3'b101, 0, 0, 0, 4'd1,  O_FETCH);
      addRow(0, 3'b101, 0, 0, 0, 4'd2,  O_NONE);
      addRow(0, 3'b101, 1, 0, 0, 4'd9,  O_JMP);
      addRow(0, 3'b101, 1, 0, 0, 4'd1,  O_FETCH);
      addRow(0, 3'b101, 0, 1, 0, 4'd2,  O_NONE);
      addRow(0, 3'b101, 0, 1, 0, 4'd9,  O_NONE);
      addRow(0, 3'b110, 0, 0, 0, 4'd1,  O_FETCH);
      addRow(0, 3'b110, 0, 0, 0, 4'd2,  O_NONE);
      addRow(0, 3'b110, 0, 1, 0, 4'd10, O_JMP);
      addRow(0, 3'b110, 0, 0, 0, 4'd1,  O_FETCH);
      addRow(0, 3'b110, 0, 0, 0, 4'd2,  O_NONE);
      addRow(0, 3'b110, 1, 0, 0, 4'd10, O_NONE);
      addRow(0, 3'b100, 0, 0, 0, 4'd1,  O_FETCH);
      addRow(0, 3'b100, 0, 0, 0, 4'd2,  O_NONE);
      addRow(0, 3'b100, 0, 0, 0, 4'd7,  O_NONE);
      addRow(0, 3'b100, 0, 0, 0, 4'd7,  O_NONE);
      addRow(0, 3'b100, 0, 0, 0, 4'd7,  O_NONE);
      addRow(0, 3'b100, 0, 0, 0, 4'd7,  O_NONE);
      addRow(0, 3'b100, 0, 0, 1, 4'd7,  O_IN);
      addRow(0, 3'b100, 0, 0, 1, 4'd8,  O_NONE);
      addRow(0, 3'b100, 0, 0, 1, 4'd8,  O_NONE);
      addRow(0, 3'b100, 0, 0, 0, 4'd8,  O_NONE);
      addRow(0, 3'b111, 0, 0, 0, 4'd1,  O_FETCH);
      addRow(0, 3'b111, 0, 0, 0, 4'd2,  O_NONE);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].ir, vecs[i].aeq0, vecs[i].apos, vecs[i].enter);
         checkOutput($sformatf("row%0d", i), vecs[i].st, vecs[i].outs);
      end

      // HALT must persist whatever the flags and key do
      for (int i = 0; i < 10; i++) begin
         logic [3:0] pat;
         pat = i[3:0];
         applyStimulus(1'b0, 3'b000, pat[1], pat[2], pat[0]);
         checkOutput($sformatf("halt%0d", i), 4'd11, O_HALT);
      end
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("halt_rst_pre", 4'd11, O_HALT);
      applyStimulus(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
      checkOutput("halt_rst_post", 4'd0, O_NONE);

      // Reset in the middle of an ADD execute cycle
      applyStimulus(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
      checkOutput("add_fetch", 4'd1, O_FETCH);
      applyStimulus(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
      checkOutput("add_decode", 4'd2, O_NONE);
      applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
      checkOutput("add_exec", 4'd5, O_ADD);
      applyStimulus(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
      checkOutput("add_rst_post", 4'd0, O_NONE);
      applyStimulus(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
      checkOutput("add_restart", 4'd1, O_FETCH);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
